operand_sequencer: RTL and testbench

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer_pkg.sv | 14 +
 rtl/operand_sequencer_accumulator.sv | 56 +++++
 rtl/operand_sequencer.sv | 159 +++++++++++++++
 tb/tb_operand_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer.
// Holds the sequencer FSM state encoding and the Mode input constants.
package operand_sequencer_pkg;

  // LOAD collects operands, SHOW replays them followed by the result.
  typedef enum logic {
    StLoad = 1'b0,
    StShow = 1'b1
  } seq_state_e;

  localparam logic MODE_ADD = 1'b0;  // acc = op0 + op1 + ...
  localparam logic MODE_SUB = 1'b1;  // acc = op0 - op1 - ...

endpackage

// File: rtl/operand_sequencer_accumulator.sv
// seq_accumulator: OUT_W-bit two's-complement running sum/difference.
// Ports:
//   clk_i     - clock, rising edge
//   rst_ni    - synchronous active-low reset, clears the accumulator
//   clear_i   - with enable_i: load the operand; alone: clear to zero
//   enable_i  - fold operand_i into the accumulator this cycle
//   mode_i    - MODE_ADD adds the operand, MODE_SUB subtracts it
//   operand_i - unsigned operand, zero-extended to OUT_W
//   acc_o     - current accumulator value
module seq_accumulator
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OUT_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [OUT_W-1:0] acc_o
);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] op_ext;

  assign op_ext = {{(OUT_W - WIDTH){1'b0}}, operand_i};

  always_comb begin
    acc_d = acc_q;
    if (enable_i) begin
      // The first operand of a batch is loaded, never subtracted from a stale value.
      if (clear_i) begin
        acc_d = op_ext;
      end else if (mode_i == MODE_SUB) begin
        acc_d = acc_q - op_ext;
      end else begin
        acc_d = acc_q + op_ext;
      end
    end else if (clear_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: collects N_OPS unsigned operands, then replays each operand
// followed by their sum (Mode=0) or op0 minus the rest (Mode=1).
// Ports:
//   Clock, Resetn          - clock (rising edge), synchronous active-low reset
//   In_valid/In_ready      - operand handshake, In_data is the operand
//   Mode                   - sampled on the slot-0 beat, held for the batch
//   Out_valid/Out_ready    - output handshake
//   Out_data, Out_tag      - operand index 0..N_OPS-1, or N_OPS for the result
//   Negative               - result sign, only set on the result word
// All outputs are registered.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OPS = 2,
  localparam int unsigned OUT_W = WIDTH + $clog2(N_OPS) + 1,
  localparam int unsigned TAG_W = $clog2(N_OPS + 1)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] In_data,
  input  logic             Mode,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [OUT_W-1:0] Out_data,
  output logic [TAG_W-1:0] Out_tag,
  output logic             Negative
);

  localparam int unsigned IDX_W = $clog2(N_OPS);
  localparam logic [TAG_W-1:0] LastSlot  = TAG_W'(N_OPS - 1);
  localparam logic [TAG_W-1:0] ResultTag = TAG_W'(N_OPS);

  seq_state_e       state_q, state_d;
  logic [TAG_W-1:0] load_idx_q, load_idx_d;
  logic [TAG_W-1:0] show_idx_q, show_idx_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] ops_q [N_OPS];
  logic [WIDTH-1:0] ops_d [N_OPS];

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             negative_q, negative_d;

  logic             beat, first_beat, out_fire;
  logic [OUT_W-1:0] acc;

  // in_ready_q is high exactly in LOAD, so it doubles as the state qualifier.
  assign beat       = In_valid & in_ready_q;
  assign first_beat = beat & (load_idx_q == '0);
  assign out_fire   = out_valid_q & Out_ready;

  seq_accumulator #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_acc (
    .clk_i     (Clock),
    .rst_ni    (Resetn),
    .clear_i   (first_beat),
    .enable_i  (beat),
    .mode_i    (mode_q),
    .operand_i (In_data),
    .acc_o     (acc)
  );

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    show_idx_d = show_idx_q;
    mode_d     = mode_q;
    ops_d      = ops_q;

    case (state_q)
      StLoad: begin
        if (beat) begin
          ops_d[load_idx_q[IDX_W-1:0]] = In_data;
          if (first_beat) begin
            mode_d = Mode;
          end
          if (load_idx_q == LastSlot) begin
            state_d    = StShow;
            load_idx_d = '0;
            show_idx_d = '0;
          end else begin
            load_idx_d = load_idx_q + TAG_W'(1);
          end
        end
      end
      StShow: begin
        if (out_fire) begin
          if (show_idx_q == ResultTag) begin
            state_d    = StLoad;
            show_idx_d = '0;
          end else begin
            show_idx_d = show_idx_q + TAG_W'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase

    // Outputs are registered from the next state, so the word appears the cycle
    // after the final beat. ops_d covers the slot written on that same beat.
    in_ready_d  = (state_d == StLoad);
    out_valid_d = (state_d == StShow);
    out_tag_d   = '0;
    out_data_d  = '0;
    negative_d  = 1'b0;
    if (state_d == StShow) begin
      out_tag_d = show_idx_d;
      if (show_idx_d == ResultTag) begin
        // The last accumulate happened on the final beat, well before this word.
        out_data_d = acc;
        negative_d = acc[OUT_W-1];
      end else begin
        out_data_d = {{(OUT_W - WIDTH){1'b0}}, ops_d[show_idx_d[IDX_W-1:0]]};
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= StLoad;
      load_idx_q  <= '0;
      show_idx_q  <= '0;
      mode_q      <= MODE_ADD;
      for (int i = 0; i < N_OPS; i++) begin
        ops_q[i] <= '0;
      end
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      negative_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_idx_q  <= load_idx_d;
      show_idx_q  <= show_idx_d;
      mode_q      <= mode_d;
      ops_q       <= ops_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      negative_q  <= negative_d;
    end
  end

  assign In_ready  = in_ready_q;
  assign Out_valid = out_valid_q;
  assign Out_data  = out_data_q;
  assign Out_tag   = out_tag_q;
  assign Negative  = negative_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: a default instance (WIDTH=8, N_OPS=2) and a
// four-operand instance share the input stimulus; sel4 picks which one is observed.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       mode = 1'b0;
  logic       out_ready = 1'b0;
  logic       sel4 = 1'b0;

  logic       in_ready2, out_valid2, neg2;
  logic [9:0] out_data2;
  logic [1:0] out_tag2;
  logic       in_ready4, out_valid4, neg4;
  logic [10:0] out_data4;
  logic [2:0] out_tag4;

  always #5 clk = ~clk;

  operand_sequencer dut2 (
    .Clock(clk), .Resetn(rstn), .In_valid(in_valid), .In_ready(in_ready2),
    .In_data(in_data), .Mode(mode), .Out_valid(out_valid2), .Out_ready(out_ready),
    .Out_data(out_data2), .Out_tag(out_tag2), .Negative(neg2)
  );

  operand_sequencer #(.WIDTH(8), .N_OPS(4)) dut4 (
    .Clock(clk), .Resetn(rstn), .In_valid(in_valid), .In_ready(in_ready4),
    .In_data(in_data), .Mode(mode), .Out_valid(out_valid4), .Out_ready(out_ready),
    .Out_data(out_data4), .Out_tag(out_tag4), .Negative(neg4)
  );

  logic        cur_valid, cur_in_ready, cur_neg;
  logic [15:0] cur_data;
  logic [3:0]  cur_tag;
  assign cur_valid    = sel4 ? out_valid4 : out_valid2;
  assign cur_in_ready = sel4 ? in_ready4 : in_ready2;
  assign cur_neg      = sel4 ? neg4 : neg2;
  assign cur_data     = sel4 ? 16'(out_data4) : 16'(out_data2);
  assign cur_tag      = sel4 ? 4'(out_tag4) : 4'(out_tag2);

  int n_checks = 0;
  int n_fail   = 0;

  // Batch description consumed by drive_batch.
  int   drv_ops [16];
  logic drv_modes [16];
  int   drv_n = 2;
  int   drv_valid_pct = 100;
  int   drv_ready_pct = 100;
  int   drv_hold_tag = 0;
  int   drv_hold_cycles = 0;

  // Words accepted by the consumer during the last batch.
  logic [15:0] got_data [$];
  logic [3:0]  got_tag [$];
  logic        got_neg [$];
  int          got_cyc [$];
  int          last_beat_cyc, first_valid_cyc, stall_cnt;

  // Expected result word: plain arithmetic over the batch, Mode taken from beat 0.
  function automatic int model_result(input int n, input int out_w);
    int acc;
    acc = drv_ops[0];
    for (int i = 1; i < n; i++) acc = drv_modes[0] ? acc - drv_ops[i] : acc + drv_ops[i];
    return acc & ((1 << out_w) - 1);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Offers drv_n operands and consumes drv_n+1 words on the selected instance.
  task automatic drive_batch();
    int   sent = 0;
    int   cyc = 0;
    int   hold_left = drv_hold_cycles;
    logic pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;
    logic [3:0]  pt = '0;
    got_data.delete(); got_tag.delete(); got_neg.delete(); got_cyc.delete();
    last_beat_cyc = -1; first_valid_cyc = -1; stall_cnt = 0;
    while (got_data.size() < drv_n + 1) begin
      @(negedge clk);
      if (cyc >= 2000) begin
        n_checks++; n_fail++;
        $display("FAIL batch_timeout: got %0d words, required %0d", got_data.size(), drv_n + 1);
        in_valid = 1'b0; out_ready = 1'b0;
        return;
      end
      if (pv && !pr) begin
        n_checks++;
        if (cur_valid !== 1'b1 || cur_data !== pd || cur_tag !== pt) begin
          n_fail++;
          $display("FAIL hold_stable: got valid %0b tag %0d data %0h, required valid 1 tag %0d data %0h",
                   cur_valid, cur_tag, cur_data, pt, pd);
        end
      end
      n_checks++;
      if (cur_in_ready !== ~cur_valid) begin
        n_fail++;
        $display("FAIL ready_vs_valid: got In_ready %0b with Out_valid %0b, required opposite",
                 cur_in_ready, cur_valid);
      end
      if (sent < drv_n) begin
        n_checks++;
        if (cur_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL early_output: got Out_valid %0b tag %0d before batch complete, required 0",
                   cur_valid, cur_tag);
        end
      end
      if (cur_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (sent < drv_n && int'($urandom_range(99)) < drv_valid_pct) begin
        in_valid = 1'b1; in_data = 8'(drv_ops[sent]); mode = drv_modes[sent];
      end else begin
        in_valid = 1'b0; in_data = 8'($urandom); mode = 1'($urandom);
      end
      if (cur_valid && hold_left > 0 && int'(cur_tag) == drv_hold_tag) begin
        out_ready = 1'b0; hold_left--; stall_cnt++;
      end else begin
        out_ready = (int'($urandom_range(99)) < drv_ready_pct);
      end
      if (in_valid && cur_in_ready) begin
        if (sent == drv_n - 1) last_beat_cyc = cyc;
        sent++;
      end
      if (cur_valid && out_ready) begin
        got_data.push_back(cur_data); got_tag.push_back(cur_tag);
        got_neg.push_back(cur_neg); got_cyc.push_back(cyc);
      end
      pv = cur_valid; pr = out_ready; pd = cur_data; pt = cur_tag;
      cyc++;
    end
  endtask

  task automatic set_plain(input int n);
    drv_n = n; drv_valid_pct = 100; drv_ready_pct = 100; drv_hold_tag = 0; drv_hold_cycles = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({in_ready2, out_valid2, out_data2, out_tag2, neg2} !== {1'b1, 1'b0, 10'd0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_dut2: got rdy %0b vld %0b data %0h tag %0d neg %0b, required 1 0 0 0 0",
               in_ready2, out_valid2, out_data2, out_tag2, neg2);
    end
    n_checks++;
    if ({in_ready4, out_valid4, out_data4, out_tag4, neg4} !== {1'b1, 1'b0, 11'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_dut4: got rdy %0b vld %0b data %0h tag %0d neg %0b, required 1 0 0 0 0",
               in_ready4, out_valid4, out_data4, out_tag4, neg4);
    end
  endtask

  task automatic test_add();
    int exp_d [3] = '{200, 100, 300};
    sel4 = 1'b0; apply_reset(); set_plain(2);
    drv_ops[0] = 200; drv_ops[1] = 100; drv_modes[0] = 1'b0; drv_modes[1] = 1'b0;
    drive_batch();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_tag[i] !== 4'(i) || got_data[i] !== 16'(exp_d[i]) || got_neg[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL add_word%0d: got tag %0d data %0d neg %0b, required tag %0d data %0d neg 0",
                 i, got_tag[i], got_data[i], got_neg[i], i, exp_d[i]);
      end
    end
    n_checks++;
    if (first_valid_cyc != last_beat_cyc + 1) begin
      n_fail++;
      $display("FAIL add_latency: got first word at cycle %0d, required %0d",
               first_valid_cyc, last_beat_cyc + 1);
    end
    n_checks++;
    if (got_cyc[2] - got_cyc[0] != 2) begin
      n_fail++;
      $display("FAIL add_throughput: got %0d cycles for 3 words, required 2", got_cyc[2] - got_cyc[0]);
    end
  endtask

  task automatic test_sub();
    sel4 = 1'b0; apply_reset(); set_plain(2);
    drv_ops[0] = 5; drv_ops[1] = 9; drv_modes[0] = 1'b1; drv_modes[1] = 1'b1;
    drive_batch();
    n_checks++;
    if (got_data[2] !== 16'h03FC || got_neg[2] !== 1'b1 || got_tag[2] !== 4'd2) begin
      n_fail++;
      $display("FAIL sub_result: got tag %0d data %0h neg %0b, required tag 2 data 3fc neg 1",
               got_tag[2], got_data[2], got_neg[2]);
    end
    n_checks++;
    if (got_data[0] !== 16'd5 || got_neg[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_op0: got data %0d neg %0b, required data 5 neg 0", got_data[0], got_neg[0]);
    end
  endtask

  task automatic test_wide_mode_hold();
    sel4 = 1'b1; apply_reset(); set_plain(4);
    for (int i = 0; i < 4; i++) begin
      drv_ops[i] = 255; drv_modes[i] = (i != 0);
    end
    drive_batch();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_tag[i] !== 4'(i) || got_data[i] !== 16'd255) begin
        n_fail++;
        $display("FAIL wide_op%0d: got tag %0d data %0d, required tag %0d data 255",
                 i, got_tag[i], got_data[i], i);
      end
    end
    n_checks++;
    if (got_tag[4] !== 4'd4 || got_data[4] !== 16'd1020 || got_neg[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_result: got tag %0d data %0d neg %0b, required tag 4 data 1020 neg 0",
               got_tag[4], got_data[4], got_neg[4]);
    end
  endtask

  task automatic test_backpressure();
    sel4 = 1'b0; apply_reset(); set_plain(2);
    drv_hold_tag = 1; drv_hold_cycles = 3;
    drv_ops[0] = 17; drv_ops[1] = 42; drv_modes[0] = 1'b0; drv_modes[1] = 1'b1;
    drive_batch();
    n_checks++;
    if (stall_cnt != 3 || got_cyc[2] - got_cyc[0] != 5) begin
      n_fail++;
      $display("FAIL bp_stall: got %0d stalls over %0d cycles, required 3 stalls over 5",
               stall_cnt, got_cyc[2] - got_cyc[0]);
    end
    n_checks++;
    if (got_tag[1] !== 4'd1 || got_data[1] !== 16'd42 || got_data[2] !== 16'd59) begin
      n_fail++;
      $display("FAIL bp_words: got tag1 %0d data1 %0d result %0d, required 1 42 59",
               got_tag[1], got_data[1], got_data[2]);
    end
    @(negedge clk);
    n_checks++;
    if (cur_valid !== 1'b0 || cur_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_extra_word: got Out_valid %0b In_ready %0b after 3 words, required 0 1",
               cur_valid, cur_in_ready);
    end
  endtask

  task automatic test_reset_mid_batch();
    int exp_d [3] = '{7, 8, 15};
    sel4 = 1'b0; apply_reset(); set_plain(2);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd99; mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    apply_reset();
    drv_ops[0] = 7; drv_ops[1] = 8; drv_modes[0] = 1'b0; drv_modes[1] = 1'b0;
    drive_batch();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_tag[i] !== 4'(i) || got_data[i] !== 16'(exp_d[i])) begin
        n_fail++;
        $display("FAIL rst_mid_word%0d: got tag %0d data %0d, required tag %0d data %0d",
                 i, got_tag[i], got_data[i], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel4 = 1'b0; apply_reset(); set_plain(2);
    drv_ops[0] = 3; drv_ops[1] = 4; drv_modes[0] = 1'b0; drv_modes[1] = 1'b0;
    drive_batch();
    n_checks++;
    if (got_data[2] !== 16'd7) begin
      n_fail++;
      $display("FAIL b2b_first: got result %0d, required 7", got_data[2]);
    end
    drv_ops[0] = 10; drv_ops[1] = 1;
    drive_batch();
    n_checks++;
    if (got_data[2] !== 16'd11 || got_data[0] !== 16'd10) begin
      n_fail++;
      $display("FAIL b2b_second: got op0 %0d result %0d, required 10 11", got_data[0], got_data[2]);
    end
    @(negedge clk);
    n_checks++;
    if (cur_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got In_ready %0b after final word, required 1", cur_in_ready);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel4 = (s == 1); apply_reset();
      drv_n = sel4 ? 4 : 2; drv_valid_pct = 70; drv_ready_pct = 60;
      drv_hold_cycles = 0;
      for (int b = 0; b < 12; b++) begin
        int res, neg, ow;
        ow = sel4 ? 11 : 10;
        for (int i = 0; i < drv_n; i++) begin
          drv_ops[i] = int'($urandom_range(255)); drv_modes[i] = 1'($urandom);
        end
        res = model_result(drv_n, ow);
        neg = (res >> (ow - 1)) & 1;
        drive_batch();
        for (int i = 0; i <= drv_n; i++) begin
          int exp_d, exp_n;
          exp_d = (i < drv_n) ? drv_ops[i] : res;
          exp_n = (i == drv_n) ? neg : 0;
          if (i < got_data.size()) begin
            n_checks++;
            if (got_tag[i] !== 4'(i) || got_data[i] !== 16'(exp_d) || got_neg[i] !== 1'(exp_n)) begin
              n_fail++;
              $display("FAIL random_word n%0d b%0d w%0d: got tag %0d data %0h neg %0b, required tag %0d data %0h neg %0d",
                       drv_n, b, i, got_tag[i], got_data[i], got_neg[i], i, exp_d, exp_n);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wide_mode_hold();
    test_backpressure();
    test_reset_mid_batch();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
